ram_cmd_master: RTL and testbench
=================================

// Module: ram_cmd_master
// PURPOSE
//   Initiator side of the RAM command interface: turns one read/write request into
//   the 10-bit command words (din[9:8] = 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data)
//   that the single-port RAM consumes on rx_valid, then returns the RAM's response.
//   Sits between a bus-style requester (test sequencer / SPI-side controller) and the RAM.
// PARAMETERS
//   ADDR_SIZE  8   RAM address width; command payload width (din = 2 + ADDR_SIZE bits)
//   TIMEOUT    15  WAIT-state cycles allowed for tx_valid before a read is errored
// PORTS
//   clk        in   1          clock, all logic on rising edge
//   rst        in   1          asynchronous, active-high reset
//   req_valid  in   1          request present
//   req_ready  out  1          request accepted when req_valid & req_ready
//   req_wr     in   1          1 = write, 0 = read
//   req_addr   in   ADDR_SIZE  target address
//   req_wdata  in   8          write data (ignored on read)
//   din        out  ADDR_SIZE+2 command word to RAM
//   rx_valid   out  1          din valid, one cycle per word
//   tx_valid   in   1          RAM read data valid
//   dout       in   8          RAM read data
//   rsp_valid  out  1          one-cycle response pulse
//   rsp_data   out  8          read data (0x00 for writes and on error)
//   rsp_err    out  1          1 = read timed out
// BEHAVIOUR
//   Reset: state IDLE; din=0, rx_valid=0, rsp_valid=0, rsp_data=0, rsp_err=0,
//     req_ready=0 while rst high, 1 from first cycle after release.
//   All outputs come from registers only (no input-to-output combinational path).
//   FSM: IDLE -> ADDR -> DATA -> (write) RESP | (read) WAIT -> RESP -> IDLE.
//   IDLE: req_ready=1; on handshake latch req_wr/addr/wdata, go ADDR. Else stay.
//   ADDR: rx_valid=1, din={wr?2'b00:2'b10, addr}; next DATA.
//   DATA: rx_valid=1; write din={2'b01,wdata} -> RESP; read din={2'b11,8'h00} -> WAIT,
//     timeout counter cleared.
//   WAIT: rx_valid=0; tx_valid -> capture dout, go RESP err=0; else count; after
//     TIMEOUT WAIT cycles without tx_valid -> RESP err=1, data 0x00.
//     tx_valid on the final allowed cycle wins over timeout.
//   RESP: rsp_valid=1 for exactly one cycle with rsp_data/rsp_err; next IDLE.
//   req_ready=0 in every state except IDLE; held req_valid not re-accepted until IDLE.
//   Latency (handshake = cycle 0): write words at cycles 1,2, rsp_valid cycle 3;
//     read words at 1,2, rsp_valid earliest cycle 4 (tx_valid at 3).
//   tx_valid outside WAIT is ignored (no capture, no state change).
//   Reset mid-operation: in-flight request dropped, no rsp_valid, all outputs to
//     reset values immediately (asynchronous).
// CONFIGURATION
//   RAM_CMD_ADDR_CACHE_EN defined: keep last-sent write address and last-sent read
//     address, each with a valid bit (cleared by reset). If new request type matches
//     and address equals the cached one, skip ADDR (IDLE -> DATA); latency drops by 1.
//     Cache updated whenever an ADDR word is sent.
//   Not defined: ADDR word always sent; no cache registers exist.
// TESTING
//   1 write addr 0x3C data 0xA5 -> din 0x03C (cyc1), 0x1A5 (cyc2), rsp_valid cyc3,
//     rsp_err=0, rsp_data=0x00.
//   2 read 0x3C, RAM model returns 0xA5 one cycle after rx_valid -> din 0x23C, 0x300,
//     rsp_valid cyc4, rsp_data=0xA5, rsp_err=0.
//   3 read 0x10, RAM never asserts tx_valid -> rsp_valid after 15 WAIT cycles,
//     rsp_err=1, rsp_data=0x00; tx_valid on 15th cycle instead -> rsp_err=0, data captured.
//   4 rst pulsed during WAIT -> rx_valid/rsp_valid stay 0, no response, req_ready=1
//     first cycle after release.
//   5 req_valid held high for two writes -> req_ready low from cyc1 to cyc3, second
//     accepted cyc4, its 0x0xx word at cyc5.
//   6 two reads of 0x3C, macro defined -> second omits 0x23C (only 0x300);
//     macro undefined -> 0x23C sent both times.

Source files
------------

// File: rtl/ram_cmd_master.sv
// Initiator for the single-port RAM command interface: request -> addr/data command words -> response.
// Optional RAM_CMD_ADDR_CACHE_EN skips the address word when it repeats the last one sent for that access type.
module ram_cmd_master #(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [7:0]           req_wdata,
    output logic [ADDR_SIZE+1:0] din,
    output logic                 rx_valid,
    input  logic                 tx_valid,
    input  logic [7:0]           dout,
    output logic                 rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 rsp_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          op_wr;
    logic [7:0]    op_wdata;
    logic          hit;
    logic          accept;

    assign accept = (state == S_IDLE) && req_valid && req_ready;

    function automatic logic [ADDR_SIZE+1:0] data_word(input logic wr, input logic [7:0] wd);
        return wr ? {2'b01, ADDR_SIZE'(wd)} : {2'b11, {ADDR_SIZE{1'b0}}};
    endfunction

`ifdef RAM_CMD_ADDR_CACHE_EN
    logic [ADDR_SIZE-1:0] wr_cache;
    logic [ADDR_SIZE-1:0] rd_cache;
    logic                 wr_cache_vld;
    logic                 rd_cache_vld;

    always_comb begin
        hit = req_wr ? (wr_cache_vld && (wr_cache == req_addr))
                     : (rd_cache_vld && (rd_cache == req_addr));
    end

    // Cache follows every address word actually issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cache     <= '0;
            rd_cache     <= '0;
            wr_cache_vld <= 1'b0;
            rd_cache_vld <= 1'b0;
        end else if (accept && !hit) begin
            if (req_wr) begin
                wr_cache     <= req_addr;
                wr_cache_vld <= 1'b1;
            end else begin
                rd_cache     <= req_addr;
                rd_cache_vld <= 1'b1;
            end
        end
    end
`else
    assign hit = 1'b0;
`endif

    // Outputs are registered one state ahead: the word for a state is loaded on the edge entering it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_wr     <= 1'b0;
            op_wdata  <= '0;
            din       <= '0;
            rx_valid  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            din       <= '0;
            rx_valid  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_wr    <= req_wr;
                        op_wdata <= req_wdata;
                        rx_valid <= 1'b1;
                        if (hit) begin
                            state <= S_DATA;
                            din   <= data_word(req_wr, req_wdata);
                        end else begin
                            state <= S_ADDR;
                            din   <= {(req_wr ? 2'b00 : 2'b10), req_addr};
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_ADDR: begin
                    state    <= S_DATA;
                    rx_valid <= 1'b1;
                    din      <= data_word(op_wr, op_wdata);
                end
                S_DATA: begin
                    if (op_wr) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    // Data arriving on the last allowed cycle takes priority over the timeout.
                    if (tx_valid) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= dout;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_cmd_master.sv
// Self-checking bench for ram_cmd_master: directed scenarios plus randomized transactions vs. a transaction-level model.
module tb_ram_cmd_master;

    localparam int AS = 8;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic [9:0]  din;
    logic        rx_valid;
    logic        tx_valid = 1'b0;
    logic [7:0]  dout = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;

    int n_assert = 0;
    int n_fail   = 0;

    // model of the address cache: last address word sent per access type
    bit         cw_v = 0;
    bit         cr_v = 0;
    logic [7:0] cw_a = '0;
    logic [7:0] cr_a = '0;

    ram_cmd_master #(.ADDR_SIZE(AS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .din(din), .rx_valid(rx_valid), .tx_valid(tx_valid), .dout(dout),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // txd: WAIT cycle (1-based) on which the RAM answers, 0 = never. hold keeps req_valid high afterwards.
    task automatic do_txn(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                          input int txd, input logic [7:0] rdata, input bit hold);
        int k;
        bit hit;
        bit spur;
        int nw;
        int rc;
        logic [9:0] words [2];
        logic [7:0] edata;
        bit eerr;

        k = 0;
        while (req_ready !== 1'b1 && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        check("req_ready_idle", req_ready, 1);

        hit = 0;
`ifdef RAM_CMD_ADDR_CACHE_EN
        hit = wr ? (cw_v && cw_a == addr) : (cr_v && cr_a == addr);
`endif
        if (!hit) begin
            if (wr) begin cw_v = 1; cw_a = addr; end
            else    begin cr_v = 1; cr_a = addr; end
        end

        nw = 0;
        if (!hit) begin
            words[nw] = {(wr ? 2'b00 : 2'b10), addr};
            nw++;
        end
        words[nw] = wr ? {2'b01, wdata} : {2'b11, 8'h00};
        nw++;

        if (wr) begin
            rc = nw + 1; edata = 8'h00; eerr = 0;
        end else if (txd != 0) begin
            rc = nw + txd + 1; edata = rdata; eerr = 0;
        end else begin
            rc = nw + TO + 1; edata = 8'h00; eerr = 1;
        end

        spur = bit'($urandom_range(0, 1));
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;

        for (int c = 1; c <= rc; c++) begin
            if (c == 1) begin
                tx_valid = spur;
                dout     = 8'($urandom);
            end else if (!wr && txd != 0 && c == nw + txd) begin
                tx_valid = 1'b1;
                dout     = rdata;
            end else begin
                tx_valid = 1'b0;
                dout     = 8'($urandom);
            end
            check("rx_valid", rx_valid, (c <= nw) ? 1 : 0);
            if (c <= nw) check("din", din, words[c-1]);
            check("rsp_valid", rsp_valid, (c == rc) ? 1 : 0);
            check("req_ready_busy", req_ready, 0);
            if (c == rc) begin
                check("rsp_data", rsp_data, edata);
                check("rsp_err", rsp_err, eerr);
            end
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
        check("rsp_valid_after", rsp_valid, 0);
        check("req_ready_after", req_ready, 1);
    endtask

    initial begin
        int k;
        bit wr;
        logic [7:0] a;

        #2;
        check("rst_din", din, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_req_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("req_ready_release", req_ready, 1);

        do_txn(1, 8'h3C, 8'hA5, 0, 8'h00, 0);
        do_txn(0, 8'h3C, 8'h00, 1, 8'hA5, 0);
        do_txn(0, 8'h10, 8'h00, 0, 8'h00, 0);
        do_txn(0, 8'h10, 8'h00, TO, 8'h5A, 0);
        do_txn(0, 8'h3C, 8'h00, 2, 8'hC3, 0);
        do_txn(0, 8'h3C, 8'h00, 3, 8'h81, 0);
        do_txn(1, 8'h20, 8'h11, 0, 8'h00, 1);
        do_txn(1, 8'h21, 8'h22, 0, 8'h00, 0);

        // reset during WAIT: request dropped, nothing answered
        k = 0;
        while (req_ready !== 1'b1 && k < 30) begin @(posedge clk); #1; k++; end
        check("req_ready_pre_rst", req_ready, 1);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_req_ready", req_ready, 0);
        check("midrst_din", din, 0);
        check("midrst_rsp_err", rsp_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cw_v = 0; cr_v = 0;
        @(posedge clk); #1;
        check("postrst_req_ready", req_ready, 1);
        for (int i = 0; i < 20; i++) begin
            tx_valid = bit'($urandom_range(0, 1));
            check("postrst_rsp_valid", rsp_valid, 0);
            check("postrst_rx_valid", rx_valid, 0);
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;

        for (int i = 0; i < 40; i++) begin
            wr = bit'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       a = 8'h3C;
                1:       a = 8'h10;
                default: a = 8'($urandom);
            endcase
            do_txn(wr, a, 8'($urandom), int'($urandom_range(0, TO)), 8'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
